// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - HI/LO multiply/divide sequencer with fixed-latency down-counter.
// Optional MADD/MSUB accumulate ops are enabled by defining MD_UNIT_MADD_EN.
module md_unit_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          busy_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic [31:0]   pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic          pend_ok, pend_ok_nxt;
  logic          accept;

  logic [63:0] prod_s, prod_u;
  logic [31:0] rs_mag, rt_mag, den_s, den_u;
  logic [31:0] q_s, r_s, q_u, r_u, div_lo_s, div_hi_s;
  logic        rt_zero;

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps instead of trapping.
  always_comb begin
    prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    rt_zero  = (rt_val == 32'd0);
    rs_mag   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    rt_mag   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    den_s    = rt_zero ? 32'd1 : rt_mag;
    den_u    = rt_zero ? 32'd1 : rt_val;
    q_s      = rs_mag / den_s;
    r_s      = rs_mag % den_s;
    q_u      = rs_val / den_u;
    r_u      = rs_val % den_u;
    div_lo_s = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_s) : q_s;
    div_hi_s = rs_val[31] ? (32'd0 - r_s) : r_s;
  end

`ifdef MD_UNIT_MADD_EN
  logic [63:0] madd_res, msub_res;
  always_comb begin
    madd_res = {hi, lo} + prod_s;
    msub_res = {hi, lo} - prod_s;
  end
`endif

  assign accept = start & ~cancel & (state == IDLE);

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    busy_nxt    = busy;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_ok_nxt = pend_ok;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_nxt, pend_lo_nxt} = (op == OP_MULT) ? prod_s : prod_u;
              pend_ok_nxt = 1'b1;
              count_nxt   = CW'(MUL_CYCLES - 1);
              state_nxt   = RUN;
              busy_nxt    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_nxt = (op == OP_DIV) ? div_hi_s : r_u;
              pend_lo_nxt = (op == OP_DIV) ? div_lo_s : q_u;
              pend_ok_nxt = ~rt_zero;
              count_nxt   = CW'(DIV_CYCLES - 1);
              state_nxt   = RUN;
              busy_nxt    = 1'b1;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MSUB: begin
              {pend_hi_nxt, pend_lo_nxt} = (op == OP_MADD) ? madd_res : msub_res;
              pend_ok_nxt = 1'b1;
              count_nxt   = CW'(MUL_CYCLES - 1);
              state_nxt   = RUN;
              busy_nxt    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (count == '0) begin
          if (pend_ok) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_ok <= pend_ok_nxt;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - directed self-checking bench for md_unit_ctrl.
// Expectations for op 6 follow whether MD_UNIT_MADD_EN is defined.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int n;

  md_unit_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c;
    tick();
    start = 1'b0; cancel = 1'b0;
  endtask

  // Counts cycles with busy high, starting right after the accept edge.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; cancel = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi_held", hi, 32'd0);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd2, 32'd77, 32'd0, 1'b0);
    wait_idle(n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_hi", hi, 32'hFFFFFFFF);
    chk("div0_lo", lo, 32'hFFFFFFFD);

    issue(3'd0, 32'd9, 32'd9, 1'b1);
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("cancel_busy2", {31'd0, busy}, 32'd0);
    chk("cancel_lo", lo, 32'hFFFFFFFD);

    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'h00001234);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_hi", hi, 32'hFFFFFFFF);
    issue(3'd4, 32'hABCD, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h0000ABCD);

    // DIVU 100/7 with a MULT attempt during RUN cycle 4 that must be dropped.
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    tick(); tick(); tick();
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    wait_idle(n);
    chk("divu_cycles_rest", n, 32'd6);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    chk("reissue_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("reissue_cycles", n, 32'd5);
    chk("reissue_lo", lo, 32'd30);
    chk("reissue_hi", hi, 32'd0);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    issue(3'd4, 32'd0, 32'd0, 1'b0);
    issue(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(3'd6, 32'd1, 32'd1, 1'b0);
`ifdef MD_UNIT_MADD_EN
    chk("madd_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("madd_cycles", n, 32'd5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
`else
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("madd_off_hi", hi, 32'd0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    // Asynchronous reset in the middle of a DIV.
    issue(3'd3, 32'd50, 32'd5, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h55, 32'd0, 1'b0);
    chk("arst_idle_mtlo", lo, 32'h55);
    tick(); tick(); tick();
    chk("arst_no_commit_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
